// File: rtl/writeback_register_file.sv
// ----------------------------------------------------------------------------
// writeback_register_file
//
// Consumer end of the execute-stage writeback path. Commits writeback beats
// into a register file, keeps a sticky two-bit status register, serves two
// registered operand read ports with same-cycle writeback bypass, and tracks
// a busy scoreboard so the issue stage can stall on pending writes.
//
// Ports
//   clock_i            single clock, rising edge
//   resetn_i           asynchronous active-low reset
//   wbEnable_i         writeback beat valid
//   wbAddress_i        destination register of the writeback
//   wbData_i           writeback data
//   statusEnable_i     statusWriteback_i is valid this cycle
//   statusWriteback_i  [1] overflow, [0] underflow
//   statusClear_i      clear the sticky status
//   claimEnable_i      issue stage reserves a destination register
//   claimAddress_i     register being reserved
//   readEnable_i       operand fetch request
//   readAddrA_i        primary operand address
//   readAddrB_i        secondary operand address
//   pOperand_o         primary operand, registered
//   sOperand_o         secondary operand, registered
//   operandValid_o     operands valid, registered
//   hazard_o           combinational stall request
//   statusReg_o        sticky status, registered
// ----------------------------------------------------------------------------
module writeback_register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clock_i,
    input  logic                  resetn_i,
    input  logic                  wbEnable_i,
    input  logic [ADDR_WIDTH-1:0] wbAddress_i,
    input  logic [DATA_WIDTH-1:0] wbData_i,
    input  logic                  statusEnable_i,
    input  logic [1:0]            statusWriteback_i,
    input  logic                  statusClear_i,
    input  logic                  claimEnable_i,
    input  logic [ADDR_WIDTH-1:0] claimAddress_i,
    input  logic                  readEnable_i,
    input  logic [ADDR_WIDTH-1:0] readAddrA_i,
    input  logic [ADDR_WIDTH-1:0] readAddrB_i,
    output logic [DATA_WIDTH-1:0] pOperand_o,
    output logic [DATA_WIDTH-1:0] sOperand_o,
    output logic                  operandValid_o,
    output logic                  hazard_o,
    output logic [1:0]            statusReg_o
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

    // ------------------------------------------------------------------
    // Decoded write / claim selects, one bit per register.
    // Register 0 is never selected, so it can neither be written nor
    // become busy.
    // ------------------------------------------------------------------
    logic [REG_COUNT-1:0]  wb_sel;
    logic [REG_COUNT-1:0]  claim_sel;
    logic [DATA_WIDTH-1:0] reg_file [REG_COUNT];
    logic [REG_COUNT-1:0]  busy;

    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign wb_sel[gi]    = 1'b0;
                assign claim_sel[gi] = 1'b0;
                assign reg_file[gi]  = '0;
                assign busy[gi]      = 1'b0;
            end else begin : g_entry
                logic [DATA_WIDTH-1:0] entry_reg;
                logic                  busy_reg;

                assign wb_sel[gi]    = wbEnable_i &&
                                       (wbAddress_i == ADDR_WIDTH'(gi));
                assign claim_sel[gi] = claimEnable_i &&
                                       (claimAddress_i == ADDR_WIDTH'(gi));

                always_ff @(posedge clock_i or negedge resetn_i) begin
                    if (!resetn_i) begin
                        entry_reg <= '0;
                    end else if (wb_sel[gi]) begin
                        entry_reg <= wbData_i;
                    end
                end

                // A claim in the same cycle as a writeback to this entry
                // means a newer producer is in flight, so the claim wins.
                always_ff @(posedge clock_i or negedge resetn_i) begin
                    if (!resetn_i) begin
                        busy_reg <= 1'b0;
                    end else if (claim_sel[gi]) begin
                        busy_reg <= 1'b1;
                    end else if (wb_sel[gi]) begin
                        busy_reg <= 1'b0;
                    end
                end

                assign reg_file[gi] = entry_reg;
                assign busy[gi]     = busy_reg;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operand lookup with same-cycle writeback bypass.
    // ------------------------------------------------------------------
    logic                  bypass_a;
    logic                  bypass_b;
    logic [DATA_WIDTH-1:0] value_a;
    logic [DATA_WIDTH-1:0] value_b;

    assign bypass_a = wbEnable_i && (wbAddress_i == readAddrA_i) &&
                      (readAddrA_i != ZERO_ADDR);
    assign bypass_b = wbEnable_i && (wbAddress_i == readAddrB_i) &&
                      (readAddrB_i != ZERO_ADDR);

    assign value_a = bypass_a ? wbData_i : reg_file[readAddrA_i];
    assign value_b = bypass_b ? wbData_i : reg_file[readAddrB_i];

    // ------------------------------------------------------------------
    // Hazard: a busy operand blocks unless its writeback lands this very
    // cycle, in which case the bypass supplies the value. Same-cycle
    // claims are deliberately not looked at here.
    // ------------------------------------------------------------------
    logic blk_a;
    logic blk_b;

    assign blk_a    = busy[readAddrA_i] && !bypass_a;
    assign blk_b    = busy[readAddrB_i] && !bypass_b;
    assign hazard_o = readEnable_i && (blk_a || blk_b);

    logic read_fire;
    assign read_fire = readEnable_i && !hazard_o;

    // ------------------------------------------------------------------
    // Registered operand outputs; values hold when no read fires.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pOperand_o     <= '0;
            sOperand_o     <= '0;
            operandValid_o <= 1'b0;
        end else begin
            operandValid_o <= read_fire;
            if (read_fire) begin
                pOperand_o <= value_a;
                sOperand_o <= value_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky status. Clear together with new flags keeps the new flags.
    // ------------------------------------------------------------------
    logic [1:0] status_next;

    always_comb begin
        status_next = statusReg_o;
        if (statusClear_i && statusEnable_i) begin
            status_next = statusWriteback_i;
        end else if (statusEnable_i) begin
            status_next = statusReg_o | statusWriteback_i;
        end else if (statusClear_i) begin
            status_next = 2'b00;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            statusReg_o <= 2'b00;
        end else begin
            statusReg_o <= status_next;
        end
    end

endmodule

// File: tb/tb_writeback_register_file.sv
// ----------------------------------------------------------------------------
// tb_writeback_register_file
//
// Drives directed and randomized writeback / claim / read / status traffic.
// A behavioural model (plain arrays) predicts every cycle's operand result,
// which is queued; a monitor pops one entry per clock and compares it with
// the registered outputs. Hazard and status are checked by the driver.
// ----------------------------------------------------------------------------
module tb_writeback_register_file;

    logic        clock_i = 1'b0;
    logic        resetn_i = 1'b0;
    logic        wbEnable_i = 1'b0;
    logic [4:0]  wbAddress_i = '0;
    logic [15:0] wbData_i = '0;
    logic        statusEnable_i = 1'b0;
    logic [1:0]  statusWriteback_i = '0;
    logic        statusClear_i = 1'b0;
    logic        claimEnable_i = 1'b0;
    logic [4:0]  claimAddress_i = '0;
    logic        readEnable_i = 1'b0;
    logic [4:0]  readAddrA_i = '0;
    logic [4:0]  readAddrB_i = '0;
    logic [15:0] pOperand_o;
    logic [15:0] sOperand_o;
    logic        operandValid_o;
    logic        hazard_o;
    logic [1:0]  statusReg_o;

    writeback_register_file dut (
        .clock_i           (clock_i),
        .resetn_i          (resetn_i),
        .wbEnable_i        (wbEnable_i),
        .wbAddress_i       (wbAddress_i),
        .wbData_i          (wbData_i),
        .statusEnable_i    (statusEnable_i),
        .statusWriteback_i (statusWriteback_i),
        .statusClear_i     (statusClear_i),
        .claimEnable_i     (claimEnable_i),
        .claimAddress_i    (claimAddress_i),
        .readEnable_i      (readEnable_i),
        .readAddrA_i       (readAddrA_i),
        .readAddrB_i       (readAddrB_i),
        .pOperand_o        (pOperand_o),
        .sOperand_o        (sOperand_o),
        .operandValid_o    (operandValid_o),
        .hazard_o          (hazard_o),
        .statusReg_o       (statusReg_o)
    );

    always #5 clock_i = ~clock_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [15:0] p;
        logic [15:0] s;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_regs [32];
    bit          m_busy [32];
    logic [1:0]  m_status;
    logic [15:0] m_p, m_s;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
        m_status = 2'b00;
        m_p = '0;
        m_s = '0;
        exp_q.delete();
    endtask

    function automatic logic [15:0] m_value(input logic [4:0] a,
                                            input logic we,
                                            input logic [4:0] wa,
                                            input logic [15:0] wd);
        if (a == 0) return 16'h0000;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic bit m_blocked(input logic [4:0] a, input logic we,
                                     input logic [4:0] wa);
        return (a != 0) && m_busy[a] && !(we && wa == a);
    endfunction

    // One clock of stimulus: check status from prior edges, drive inputs,
    // check the combinational hazard, queue the expected result and advance
    // the model to the state after the coming edge.
    task automatic cycle(input logic we, input logic [4:0] wa,
                         input logic [15:0] wd, input logic se,
                         input logic [1:0] sw, input logic sc,
                         input logic ce, input logic [4:0] ca,
                         input logic re, input logic [4:0] ra,
                         input logic [4:0] rb);
        bit   exp_hz;
        exp_t e;
        @(negedge clock_i);
        check("status", {30'd0, statusReg_o}, {30'd0, m_status});
        wbEnable_i = we; wbAddress_i = wa; wbData_i = wd;
        statusEnable_i = se; statusWriteback_i = sw; statusClear_i = sc;
        claimEnable_i = ce; claimAddress_i = ca;
        readEnable_i = re; readAddrA_i = ra; readAddrB_i = rb;
        #1;
        exp_hz = re && (m_blocked(ra, we, wa) || m_blocked(rb, we, wa));
        check("hazard", {31'd0, hazard_o}, {31'd0, exp_hz});
        e.valid = re && !exp_hz;
        if (e.valid) begin
            m_p = m_value(ra, we, wa, wd);
            m_s = m_value(rb, we, wa, wd);
        end
        e.p = m_p;
        e.s = m_s;
        exp_q.push_back(e);
        $display("cyc we=%0d wa=%0d wd=%h ce=%0d ca=%0d re=%0d a=%0d b=%0d hz=%0d st=%b",
                 we, wa, wd, ce, ca, re, ra, rb, exp_hz, m_status);
        if (we && wa != 0) begin
            m_regs[wa] = wd;
            m_busy[wa] = 0;
        end
        if (ce && ca != 0) m_busy[ca] = 1;
        if (se && sc)      m_status = sw;
        else if (se)       m_status = m_status | sw;
        else if (sc)       m_status = 2'b00;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_idle_inputs();
        wbEnable_i = 0; statusEnable_i = 0; statusClear_i = 0;
        claimEnable_i = 0; readEnable_i = 0;
    endtask

    // Reset asserted away from any clock edge; outputs must clear at once.
    task automatic do_reset();
        exp_t e;
        @(negedge clock_i);
        #3;
        resetn_i = 1'b0;
        set_idle_inputs();
        model_reset();
        #1;
        check("rst_p",     {16'd0, pOperand_o}, 32'd0);
        check("rst_s",     {16'd0, sOperand_o}, 32'd0);
        check("rst_valid", {31'd0, operandValid_o}, 32'd0);
        check("rst_status", {30'd0, statusReg_o}, 32'd0);
        $display("reset asserted at %0t", $time);
        repeat (2) @(negedge clock_i);
        resetn_i = 1'b1;
        e = '0;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clock_i) begin
        exp_t e;
        #1;
        if (resetn_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL monitor: DUT output with no expectation at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("valid", {31'd0, operandValid_o}, {31'd0, e.valid});
                check("p_operand", {16'd0, pOperand_o}, {16'd0, e.p});
                check("s_operand", {16'd0, sOperand_o}, {16'd0, e.s});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        do_reset();

        // write r5, then read A=5 B=0
        cycle(1, 5, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        // same-cycle bypass
        cycle(1, 7, 16'hBEEF, 0, 0, 0, 0, 0, 1, 7, 5);
        // r0 stays zero, claim of r0 never blocks
        cycle(1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // claim r3, stall, resolve via writeback bypass
        cycle(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        cycle(1, 3, 16'h0042, 0, 0, 0, 0, 0, 1, 3, 0);
        idle();
        // claim and writeback r9 together: claim wins
        cycle(1, 9, 16'h0999, 0, 0, 0, 1, 9, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 9);
        cycle(1, 9, 16'h0AAA, 0, 0, 0, 0, 0, 1, 9, 9);
        idle();
        // same-cycle claim does not raise hazard
        cycle(0, 0, 0, 0, 0, 0, 1, 11, 1, 11, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 0);
        // status
        cycle(0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0);
        idle();
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 2'b11, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 2'b01, 1, 0, 0, 0, 0, 0);
        idle();
        // reset mid-sequence discards claims
        cycle(0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0);
        cycle(0, 0, 0, 1, 2'b10, 0, 0, 0, 1, 5, 7);
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 5);
        idle();

        // randomized traffic over a small address window to force collisions
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 2) == 0,
                      5'($urandom_range(0, 7)),
                      16'($urandom),
                      $urandom_range(0, 4) == 0,
                      2'($urandom),
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 3) == 0,
                      5'($urandom_range(0, 7)),
                      $urandom_range(0, 1) == 1,
                      5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)));
            end
        end

        idle();
        @(posedge clock_i);
        #2;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
